// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states, halt word and
// the buffered (instruction, pc) entry.
package ifu_pkg;
    localparam int IFU_ADDR_W = 10;
    localparam int IFU_DATA_W = 32;
    localparam logic [IFU_DATA_W-1:0] IFU_HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IFU_IDLE, IFU_FETCH, IFU_DRAIN} ifu_state_e;

    typedef struct packed {
        logic [IFU_DATA_W-1:0] data;
        logic [IFU_ADDR_W-1:0] pc;
    } ifu_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head is valid whenever
// count is non-zero. Callers never push when full or pop when empty.
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rd_ptr, wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher on RAM port 2: credit-limited reads into a
// FWFT buffer, halt detection, and branch redirect.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W      = IFU_ADDR_W,
    parameter int                DATA_W      = IFU_DATA_W,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [DATA_W-1:0] HALT_OPCODE = IFU_HALT_OPCODE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    ifu_state_e        state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, inflight_pc;
    logic              inflight, done_q, done_nxt;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit;
    logic              fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic              resp_live, bypass, resp_halt, accept, issue;
    ifu_entry_t        push_entry, head_entry;

    // A response arriving while the buffer is empty is presented directly,
    // giving the two-cycle start-up latency and one word per cycle.
    assign resp_live  = inflight && (state == IFU_FETCH);
    assign bypass     = resp_live && fifo_empty;
    assign resp_halt  = resp_live && (mem_readdata == HALT_OPCODE);
    assign fifo_flush = redirect && (state != IFU_IDLE);
    assign accept     = instr_valid && instr_ready && !fifo_flush;
    assign fifo_pop   = accept && !fifo_empty;
    assign fifo_push  = resp_live && !(bypass && accept) && !fifo_flush;
    assign credit     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue      = (state == IFU_FETCH) && !redirect && (credit < DEPTH_C);

    assign push_entry = '{data: mem_readdata, pc: inflight_pc};

    ifu_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ifu_entry_t))) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IFU_IDLE:
                if (start) state_nxt = IFU_FETCH;
            IFU_FETCH:
                if (redirect) state_nxt = IFU_FETCH;
                else if (resp_halt) begin
                    if (bypass && accept) begin
                        state_nxt = IFU_IDLE;
                        done_nxt  = 1'b1;
                    end else
                        state_nxt = IFU_DRAIN;
                end
            IFU_DRAIN:
                if (redirect) state_nxt = IFU_FETCH;
                else if (fifo_pop && head_entry.data == HALT_OPCODE) begin
                    state_nxt = IFU_IDLE;
                    done_nxt  = 1'b1;
                end
            default: state_nxt = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IFU_IDLE;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            done_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_q   <= done_nxt;
            inflight <= issue;
            if (issue)
                inflight_pc <= fetch_pc;
            if (state == IFU_IDLE && start)
                fetch_pc <= start_pc;
            else if (fifo_flush)
                fetch_pc <= redirect_pc;
            else if (issue)
                fetch_pc <= fetch_pc + 1'b1;
        end
    end

    assign busy           = (state != IFU_IDLE);
    assign done           = done_q;
    assign instr_valid    = !fifo_empty || resp_live;
    assign instr_data     = !fifo_empty ? head_entry.data : (resp_live ? mem_readdata : '0);
    assign instr_pc       = !fifo_empty ? head_entry.pc   : (resp_live ? inflight_pc  : '0);
    assign mem_address    = fetch_pc;
    assign mem_chipselect = issue;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_writedata  = '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: RAM model on port 2, queue-based stream model
// checked every cycle, directed scenarios with literal expectations, random run.
module tb_instr_fetch_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h2222_0002, WC = 32'h3333_0003;
    localparam logic [31:0] WD = 32'h4444_0004, WX = 32'h5555_0005, WY = 32'h6666_0006;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
    logic [9:0]  start_pc = '0, redirect_pc = '0;
    logic        busy, done, mem_chipselect, mem_clken, mem_write, instr_valid;
    logic [9:0]  mem_address, instr_pc;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata, instr_data;
    logic [31:0] ram [0:1023];
    logic [31:0] rd_q = '0;
    int          checks = 0, errors = 0, cyc = 0;

    typedef struct { logic [31:0] data; logic [9:0] pc; } exp_t;
    typedef struct { logic [31:0] data; logic [9:0] pc; int c; } log_t;
    exp_t exp_q[$];
    log_t hs_log[$];
    exp_t e;
    log_t l;
    bit   model_busy = 0, done_due = 0, nxt_done = 0, was_busy = 0;
    int   done_cyc = -1, n_deliv = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect) rd_q <= ram[mem_address];
    end
    assign mem_readdata = rd_q;

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream: sequential words from pc0 up to and including the first halt.
    function automatic void build(input logic [9:0] pc0);
        logic [9:0] pc = pc0;
        exp_t x;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            x.data = ram[pc];
            x.pc   = pc;
            exp_q.push_back(x);
            if (ram[pc] == HALT) break;
            pc = pc + 10'd1;
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                model_busy = 0;
                done_due   = 0;
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                chk("reset_valid", instr_valid, 0);
                chk("reset_cs", mem_chipselect, 0);
                chk("reset_addr", mem_address, 0);
                chk("reset_data", instr_data, 0);
                chk("reset_pc", instr_pc, 0);
            end else begin
                chk("done", done, done_due);
                chk("busy", busy, model_busy);
                if (instr_valid) begin
                    if (exp_q.size() == 0) chk("spurious_valid", instr_valid, 0);
                    else begin
                        chk("instr_data", instr_data, exp_q[0].data);
                        chk("instr_pc", instr_pc, exp_q[0].pc);
                    end
                end
                nxt_done = 0;
                was_busy = model_busy;
                if (redirect && was_busy) build(redirect_pc);
                else if (instr_valid && instr_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    l.data = instr_data; l.pc = instr_pc; l.c = cyc;
                    hs_log.push_back(l);
                    n_deliv++;
                    if (e.data == HALT) begin
                        model_busy = 0;
                        nxt_done   = 1;
                    end
                end
                if (start && !was_busy) begin
                    build(start_pc);
                    model_busy = 1;
                end
                done_due = nxt_done;
                if (done) done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] pc);
        start = 1'b1; start_pc = pc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy || model_busy || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, n >= bound, 0);
        tick();
        tick();
    endtask

    task automatic exp_hs(input string name, input int i, input logic [31:0] d,
                          input logic [9:0] pc, input int c);
        if (i >= hs_log.size()) chk($sformatf("%s_hs%0d_missing", name, i), hs_log.size(), i + 1);
        else begin
            chk($sformatf("%s_hs%0d_data", name, i), hs_log[i].data, d);
            chk($sformatf("%s_hs%0d_pc", name, i), hs_log[i].pc, pc);
            if (c >= 0) chk($sformatf("%s_hs%0d_cycle", name, i), hs_log[i].c, c);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + i;
        ram[10'h010] = WA; ram[10'h011] = WB; ram[10'h012] = WC; ram[10'h013] = HALT;
        ram[10'h040] = WD; ram[10'h041] = HALT;
        ram[10'h3FE] = WX; ram[10'h3FF] = WY; ram[10'h000] = HALT;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        load_prog();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // 1: straight-line program, ready held high
        instr_ready = 1'b1; hs_log.delete(); done_cyc = -1;
        c0 = cyc;
        do_start(10'h010);
        wait_idle("t1", 50);
        chk("t1_count", hs_log.size(), 4);
        exp_hs("t1", 0, WA, 10'h010, c0 + 2);
        exp_hs("t1", 1, WB, 10'h011, c0 + 3);
        exp_hs("t1", 2, WC, 10'h012, c0 + 4);
        exp_hs("t1", 3, HALT, 10'h013, c0 + 5);
        chk("t1_done_cycle", done_cyc, c0 + 6);
        chk("t1_busy_after", busy, 0);

        // 2: back-pressure fills the buffer, then drains in order
        instr_ready = 1'b0; hs_log.delete();
        do_start(10'h010);
        repeat (20) tick();
        chk("t2_cs_held", mem_chipselect, 0);
        chk("t2_valid_held", instr_valid, 1);
        chk("t2_head_pc", instr_pc, 10'h010);
        chk("t2_head_data", instr_data, WA);
        instr_ready = 1'b1;
        c0 = cyc;
        wait_idle("t2", 50);
        chk("t2_count", hs_log.size(), 4);
        exp_hs("t2", 0, WA, 10'h010, c0);
        exp_hs("t2", 1, WB, 10'h011, c0 + 1);
        exp_hs("t2", 2, WC, 10'h012, c0 + 2);
        exp_hs("t2", 3, HALT, 10'h013, c0 + 3);

        // 3: pc wraps from 0x3FF to 0x000
        hs_log.delete();
        do_start(10'h3FE);
        wait_idle("t3", 50);
        chk("t3_count", hs_log.size(), 3);
        exp_hs("t3", 0, WX, 10'h3FE, -1);
        exp_hs("t3", 1, WY, 10'h3FF, -1);
        exp_hs("t3", 2, HALT, 10'h000, -1);

        // 4: redirect while pc 0x11 is being presented
        hs_log.delete();
        c0 = cyc;
        do_start(10'h010);
        n = 0;
        while (!(instr_valid && instr_pc == 10'h011) && n < 20) begin tick(); n++; end
        chk("t4_wait_pc11_timeout", n >= 20, 0);
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        wait_idle("t4", 50);
        chk("t4_count", hs_log.size(), 3);
        exp_hs("t4", 0, WA, 10'h010, c0 + 2);
        exp_hs("t4", 1, WD, 10'h040, c0 + 5);
        exp_hs("t4", 2, HALT, 10'h041, c0 + 6);

        // 5a: redirect while draining
        instr_ready = 1'b0; hs_log.delete();
        do_start(10'h010);
        repeat (10) tick();
        chk("t5a_busy_drain", busy, 1);
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        instr_ready = 1'b1;
        wait_idle("t5a", 50);
        chk("t5a_count", hs_log.size(), 2);
        exp_hs("t5a", 0, WD, 10'h040, -1);
        exp_hs("t5a", 1, HALT, 10'h041, -1);

        // 5b: reset mid-fetch clears outputs immediately
        do_start(10'h010);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t5b_busy", busy, 0);
        chk("t5b_valid", instr_valid, 0);
        chk("t5b_cs", mem_chipselect, 0);
        chk("t5b_addr", mem_address, 0);
        chk("t5b_data", instr_data, 0);
        chk("t5b_pc", instr_pc, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // 5c: redirect in idle ignored; start while busy ignored
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        tick();
        chk("t5c_idle_busy", busy, 0);
        chk("t5c_idle_valid", instr_valid, 0);
        hs_log.delete();
        do_start(10'h010);
        tick();
        do_start(10'h040);
        wait_idle("t5c", 50);
        chk("t5c_count", hs_log.size(), 4);
        exp_hs("t5c", 0, WA, 10'h010, -1);
        exp_hs("t5c", 3, HALT, 10'h013, -1);

        // 6: random programs, ready, starts and redirects
        for (int i = 0; i < 1024; i++)
            ram[i] = ($urandom_range(7) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
        ram[$urandom_range(1023)] = HALT;
        n_deliv = 0;
        for (int i = 0; i < 2000; i++) begin
            instr_ready = ($urandom_range(9) < 7);
            start       = ($urandom_range(11) == 0);
            start_pc    = 10'($urandom_range(1023));
            redirect    = ($urandom_range(29) == 0);
            redirect_pc = 10'($urandom_range(1023));
            tick();
        end
        start = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
        wait_idle("t6", 3000);
        chk("t6_activity", n_deliv > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
